// File: rtl/adder_18_sync_pkg.sv
// adder_18_sync_pkg: shared widths and {a, b, cin} leaf bit-field positions
package adder_18_sync_pkg;
  localparam int ADD18_W     = 3;
  localparam int ADD18_SUM_W = 4;
  localparam int ADD18_A_MSB = 6;
  localparam int ADD18_A_LSB = 4;
  localparam int ADD18_B_MSB = 3;
  localparam int ADD18_B_LSB = 1;
  localparam int ADD18_CIN   = 0;
endpackage

// File: rtl/adder_18_fa.sv
// adder_18_fa: 1-bit full adder; a, b, ci in -> s, co out
module adder_18_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/adder_18_sync.sv
// adder_18_sync: registered a+b+cin ripple adder; clk, rst_n, in_valid, a, b, cin in -> sum, out_valid out
module adder_18_sync
  import adder_18_sync_pkg::*;
#(
  parameter int WIDTH = ADD18_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   sum,
  output logic             out_valid
);
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH:0]   r_sum;
  logic             r_valid;
  assign w_c[0] = cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    adder_18_fa u_fa (.a(a[i]), .b(b[i]), .ci(w_c[i]), .s(w_p[i]), .co(w_c[i+1]));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) r_sum <= {w_c[WIDTH], w_p};
    end
  end
  assign sum       = r_sum;
  assign out_valid = r_valid;
endmodule

// File: tb/tb_adder_18_sync.sv
// tb_adder_18_sync: scoreboard bench for adder_18_sync against an arithmetic model
module tb_adder_18_sync;
  typedef struct packed {
    logic       v;
    logic [3:0] s;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] a = '0;
  logic [2:0] b = '0;
  logic       cin = 1'b0;
  logic [3:0] sum;
  logic       out_valid;
  exp_t       q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         m_sum = 0;
  bit         done = 1'b0;
  adder_18_sync dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
    .sum(sum), .out_valid(out_valid)
  );
  always #5 clk = ~clk;
  task automatic step(input logic r, input logic v, input int av, input int bv, input int cv);
    exp_t e;
    rst_n    = r;
    in_valid = v;
    a        = 3'(av);
    b        = 3'(bv);
    cin      = 1'(cv);
    @(posedge clk);
    if (!r) m_sum = 0;
    else if (v) m_sum = av + bv + cv;
    e.v = r && v;
    e.s = 4'(m_sum);
    q.push_back(e);
    #1;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_vec++;
      if (out_valid !== e.v || sum !== e.s) begin
        n_err++;
        $display("FAIL vec%0d a=%0d b=%0d cin=%0d: got valid=%b sum=%b, want valid=%b sum=%b",
                 n_vec, a, b, cin, out_valid, sum, e.v, e.s);
      end
    end
  end
  initial begin
    step(0, 1, 7, 7, 1);
    step(0, 1, 7, 7, 1);
    for (int i = 0; i < 128; i++) step(1, 1, (i >> 4) & 7, (i >> 1) & 7, i & 1);
    step(1, 1, 5, 2, 0);
    step(1, 0, 3, 3, 0);
    step(1, 0, 3, 3, 1);
    step(1, 1, 4, 4, 0);
    step(1, 1, 6, 1, 1);
    step(0, 1, 3, 4, 1);
    step(1, 1, 1, 1, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 7, 0, 1);
    step(1, 1, 0, 7, 1);
    step(1, 1, 4, 4, 0);
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 15) != 0), ($urandom_range(0, 2) != 0),
           $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1));
    done = 1'b1;
  end
  initial begin
    int t = 0;
    while (!(done && q.size() == 0) && t < 2000) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk);
    if (q.size() != 0 || t >= 2000) begin
      n_err++;
      $display("FAIL drain: %0d expected results left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/adder_18_sync.md
Name:
adder_18_sync

Overview:
- Registered 3-bit + 3-bit + carry-in adder producing a 4-bit unsigned sum.
- The combinational sum function is the 7-input / 4-output leaf of the partitioned adder datapath.
- The sync wrapper adds a one-cycle pipeline register with valid tracking, so the leaf drops into clocked datapaths.
- The combinational function is exhaustively checkable over all 128 input codes.

Parameters:
- WIDTH, 3, operand width in bits. Sum width is WIDTH+1. Only the default is verified.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands and carry-in valid this cycle
- a  input  WIDTH  operand A, unsigned; maps to leaf inputs 6..4, MSB first
- b  input  WIDTH  operand B, unsigned; maps to leaf inputs 3..1, MSB first
- cin  input  1  carry-in; maps to leaf input 0
- sum  output  WIDTH+1  registered a+b+cin; maps to leaf outputs 3..0, MSB first
- out_valid  output  1  sum holds a result captured from a valid input

Behaviour:
- Combinational function: s = a + b + cin, computed at WIDTH+1 bits with no truncation.
  - Maximum is 7+7+1 = 15, so the result never overflows.
  - As a 7-bit index, the input packs as {a, b, cin}, bit 6 down to bit 0.
- Register update, on each rising clk edge:
  - rst_n = 0: sum <= 0 and out_valid <= 0, regardless of in_valid.
  - else if in_valid = 1: sum <= s and out_valid <= 1.
  - else: sum holds its previous value and out_valid <= 0.
- Latency is exactly 1 cycle. Throughput is one result per cycle, with back-to-back valid inputs accepted.
- There is no backpressure; the consumer must sample whenever out_valid = 1.
- Reset mid-stream discards any in-flight result.
  - The first valid input after rst_n rises appears one cycle later.
- When in_valid = 0, X or undefined operand values must not propagate into sum.
  - Implement this by gating the capture enable, not by muxing the data.
- No internal state exists beyond the sum register and out_valid.

Decomposition:
- Shared package holds:
  - localparam ADD18_W = 3
  - localparam ADD18_SUM_W = 4
  - the {a, b, cin} bit-field positions (6:4, 3:1, 0)
- Natural sub-module: adder_18_fa, a 1-bit full adder.
  - Instantiate it WIDTH times in a ripple chain.
  - Chain carry-in is cin; sum MSB is the final carry-out.
- The wrapper holds only the chain, the enable-gated register and out_valid.

Test Plan:
- Reset: rst_n = 0 for 2 cycles with in_valid = 1, a = 7, b = 7, cin = 1 -> sum = 0000, out_valid = 0 every cycle.
- Exhaustive sweep: drive in_valid = 1 and step {a, b, cin} through 0..127, one per cycle -> each following cycle sum = a+b+cin and out_valid = 1.
  - Spot checks: code 0000000 -> 0000; 0000001 -> 0001; 0010110 (a=1, b=3, cin=0) -> 0100; 1111111 -> 1111.
- Hold: a = 5, b = 2, cin = 0 valid (sum = 0111), then in_valid = 0 with a = 3, b = 3 -> sum stays 0111 and out_valid = 0.
- Back-to-back: (a=4, b=4, cin=0) then (a=6, b=1, cin=1) on consecutive cycles -> sum = 1000 then 1000, out_valid high both cycles.
  - Consecutive equal results must not glitch out_valid.
- Reset mid-stream: valid a = 3, b = 4, cin = 1 with rst_n = 0 in the same cycle -> next cycle sum = 0, out_valid = 0.
  - Release rst_n and apply a = 1, b = 1, cin = 0 -> one cycle later sum = 0010.
- Carry chain: a = 7, b = 0, cin = 1 -> 1000; a = 0, b = 7, cin = 1 -> 1000; a = 4, b = 4, cin = 0 -> 1000.
